// File: rtl/axi_lite_regfile_if.sv
// AXI4-Lite bus bundle for axi_lite_regfile: the master drives requests, the slave drives responses.
interface axi_lite_regfile_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_regfile.sv
// Parametrised AXI4-Lite register file with byte strobes, decoupled AW/W and SLVERR on bad indices.
// Define AXIL_REGFILE_ERRCNT_EN to add a saturating 16-bit err_cnt output counting SLVERR responses.
module axi_lite_regfile #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic                aclk,
  input  logic                areset,
  axi_lite_regfile_if.slave   s_axi
`ifdef AXIL_REGFILE_ERRCNT_EN
  ,
  output logic [15:0]         err_cnt
`endif
);
  localparam int STRB_W    = DATA_W / 8;
  localparam int OFFS_W    = $clog2(STRB_W);
  localparam int IDX_W     = ADDR_W - OFFS_W;
  localparam int MEM_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                aw_hold_reg;
  logic                w_hold_reg;
  logic [ADDR_W-1:0]   awaddr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [STRB_W-1:0]   wstrb_reg;
  logic                bvalid_reg;
  logic [1:0]          bresp_reg;
  logic                rvalid_reg;
  logic [1:0]          rresp_reg;
  logic [DATA_W-1:0]   rdata_reg;

  logic                aw_hs;
  logic                w_hs;
  logic                b_hs;
  logic                ar_hs;
  logic                r_hs;
  logic                commit;
  logic [ADDR_W-1:0]   waddr_next;
  logic [DATA_W-1:0]   wdata_next;
  logic [STRB_W-1:0]   wstrb_next;
  logic [IDX_W-1:0]    widx;
  logic [IDX_W-1:0]    ridx;
  logic                w_in_range;
  logic                r_in_range;
  logic [DATA_W-1:0]   rd_word;
  logic                unused_addr_bits;

  assign s_axi.awready = !areset && !aw_hold_reg && !bvalid_reg;
  assign s_axi.wready  = !areset && !w_hold_reg && !bvalid_reg;
  assign s_axi.arready = !areset && !rvalid_reg;
  assign s_axi.bvalid  = bvalid_reg;
  assign s_axi.bresp   = bresp_reg;
  assign s_axi.rvalid  = rvalid_reg;
  assign s_axi.rresp   = rresp_reg;
  assign s_axi.rdata   = rdata_reg;

  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_hs  = s_axi.wvalid && s_axi.wready;
  assign b_hs  = bvalid_reg && s_axi.bready;
  assign ar_hs = s_axi.arvalid && s_axi.arready;
  assign r_hs  = rvalid_reg && s_axi.rready;

  // The write commits on the edge that completes the later of the two handshakes.
  assign commit = (aw_hs || w_hs) && (aw_hs || aw_hold_reg) && (w_hs || w_hold_reg);

  assign waddr_next = aw_hs ? s_axi.awaddr : awaddr_reg;
  assign wdata_next = w_hs ? s_axi.wdata : wdata_reg;
  assign wstrb_next = w_hs ? s_axi.wstrb : wstrb_reg;

  assign widx       = waddr_next[ADDR_W-1:OFFS_W];
  assign ridx       = s_axi.araddr[ADDR_W-1:OFFS_W];
  assign w_in_range = {1'b0, widx} < (IDX_W + 1)'(DEPTH);
  assign r_in_range = {1'b0, ridx} < (IDX_W + 1)'(DEPTH);

  assign unused_addr_bits = &{1'b0, waddr_next[OFFS_W-1:0], s_axi.araddr[OFFS_W-1:0]};

  // One memory per byte lane so each strobe bit owns its storage outright.
  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];

      always_ff @(posedge aclk) begin
        if (areset) begin
          for (int r = 0; r < DEPTH; r++) begin
            lane_mem[r] <= '0;
          end
        end else if (commit && w_in_range && wstrb_next[gi]) begin
          lane_mem[widx[MEM_IDX_W-1:0]] <= wdata_next[gi*8 +: 8];
        end
      end

      assign rd_word[gi*8 +: 8] = lane_mem[ridx[MEM_IDX_W-1:0]];
    end
  endgenerate

  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_hold_reg <= 1'b0;
      w_hold_reg  <= 1'b0;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
      rvalid_reg  <= 1'b0;
      rresp_reg   <= RESP_OKAY;
      rdata_reg   <= '0;
    end else begin
      if (aw_hs) begin
        aw_hold_reg <= 1'b1;
        awaddr_reg  <= s_axi.awaddr;
      end
      if (w_hs) begin
        w_hold_reg <= 1'b1;
        wdata_reg  <= s_axi.wdata;
        wstrb_reg  <= s_axi.wstrb;
      end
      // Hold flags stay set while B is pending so neither channel re-opens early.
      if (commit) begin
        bvalid_reg <= 1'b1;
        bresp_reg  <= w_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (b_hs) begin
        bvalid_reg  <= 1'b0;
        aw_hold_reg <= 1'b0;
        w_hold_reg  <= 1'b0;
      end

      if (ar_hs) begin
        rvalid_reg <= 1'b1;
        rresp_reg  <= r_in_range ? RESP_OKAY : RESP_SLVERR;
        rdata_reg  <= r_in_range ? rd_word : '0;
      end else if (r_hs) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

`ifdef AXIL_REGFILE_ERRCNT_EN
  logic [15:0] err_cnt_reg;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  assign err_inc = {1'b0, commit && !w_in_range} + {1'b0, ar_hs && !r_in_range};
  assign err_sum = {1'b0, err_cnt_reg} + {15'd0, err_inc};

  always_ff @(posedge aclk) begin
    if (areset) begin
      err_cnt_reg <= '0;
    end else begin
      err_cnt_reg <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  assign err_cnt = err_cnt_reg;
`endif
endmodule

// File: doc/axi_lite_regfile.md
Name: axi_lite_regfile

Overview:
- Parametrised AXI4-Lite slave register file.
- Next generation of the team's single-FSM AXI-Lite slave, adding:
  - configurable data width, address width and register depth
  - byte strobes
  - independent AW/W acceptance in any order
  - concurrent read and write channels
  - SLVERR on out-of-range addresses
- Sits behind the AXI-Lite interconnect as a generic control/status register bank.

Parameters:
- ADDR_W, 32, AXI address width in bits.
- DATA_W, 32, data width in bits; must be 32 or 64.
- DEPTH, 32, number of DATA_W-bit registers; >=1, need not be a power of two.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- s_axi_awaddr  in  ADDR_W  write address
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  DATA_W  write data
- s_axi_wstrb  in  DATA_W/8  byte strobes
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  ADDR_W  read address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  DATA_W  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready

Behaviour:
- Clocking and reset: one clock, aclk. Reset is synchronous and active-high on areset, sampled at posedge aclk.
- Reset values:
  - all readys 0 while areset is high
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0
  - all registers 0, aw/w hold flags cleared
- Reset mid-transaction drops all pending state; no response is issued for it.
- Address decode:
  - index = addr[ADDR_W-1 : log2(DATA_W/8)]; low byte-offset bits are ignored.
  - index >= DEPTH is out of range.
- Write path (at most one write outstanding):
  - awready = !areset && !aw_hold && !bvalid; wready = !areset && !w_hold && !bvalid.
  - AW and W may handshake in the same cycle or either first. The first to arrive is latched and its hold flag set; its ready drops next cycle.
  - At the edge where the second handshake completes:
    - in range: register bytes with wstrb[i]=1 are updated; others unchanged.
    - out of range: no register changes.
    - bvalid rises in the next cycle: bresp=2'b00 OKAY in range, 2'b10 SLVERR out of range.
  - bvalid, bresp held stable until bready. At the B handshake edge, hold flags clear; awready/wready return high in the following cycle.
  - Best case: AW+W same cycle N, B visible in cycle N+1, next AW accepted in cycle N+2 if bready was high in N+1.
- Read path (one outstanding read, independent of the write path):
  - arready = !areset && !rvalid.
  - AR handshake at edge N → rvalid, rdata, rresp valid in cycle N+1.
    - rdata = register contents sampled at edge N; rresp=OKAY.
    - out of range: rdata=0, rresp=SLVERR.
  - rdata, rresp held stable until rready. arready returns high the cycle after the R handshake.
- Simultaneous events:
  - A read handshaking at the same edge a write commits to the same index returns the pre-write value.
  - A read in a later cycle sees the new value.
- Valid signals never depend combinationally on ready inputs. No output is combinational from inputs except via the registered hold flags.

Optional Feature:
- Macro: AXIL_REGFILE_ERRCNT_EN.
- Defined:
  - Adds output port err_cnt (16 bits).
  - Increments by 1 at each edge where a SLVERR response is launched (B or R). If both launch at the same edge, it increments by 2.
  - Saturates at 16'hFFFF. Reset to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset, then idle: check awready=wready=arready=1 in the first cycle after areset falls; bvalid=rvalid=0; read of index 0..DEPTH-1 returns 0 with OKAY.
- AW+W same cycle, addr 0x08, data 0xDEADBEEF, wstrb 4'hF → bvalid next cycle, bresp=0. Read 0x08 → rdata 0xDEADBEEF, rvalid one cycle after AR.
- W first (0x11223344, wstrb 4'b0101), AW 3 cycles later to 0x08 holding 0xDEADBEEF → awready stays 1 and wready drops while waiting. Read-back 0xDE22BE44.
- Write to index DEPTH (addr DEPTH*4 with DATA_W=32) → bresp=2'b10, no register changes. Read of the same address → rdata=0, rresp=2'b10. With AXIL_REGFILE_ERRCNT_EN: err_cnt=2.
- Backpressure: hold bready=0 and rready=0 for 5 cycles → bvalid/rvalid and their data stay stable; awready/wready/arready stay 0; no further handshakes accepted.
- Same-edge read and write to 0x0C (old value 0x0, new value 0x5) → that read returns 0x0; a read on the next cycle returns 0x5. Assert areset during a pending B → bvalid=0 at the next edge, registers cleared.
